// File: rtl/kamikaze_compress_encoder.sv
// kamikaze_compress_encoder
// Replaces RV32I instructions with their exact RVC equivalent where one exists and packs the
// resulting 16/32-bit stream into aligned 32-bit words, lower halfword first.
// Optional feature macro: KAMIKAZE_CENC_STATS_EN (adds stat_c_o / stat_w_o counters).
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   in_valid_i/in_ready_o   input handshake, in_instr_i carries one RV32I instruction
//   flush_i                 level; emits a pending halfword padded with c.nop
//   out_valid_o/out_ready_i output handshake, out_word_o[15:0] is the earlier halfword
//   err_o                   1-cycle pulse after a rejected (non-32-bit) input
//   stat_c_o/stat_w_o       saturating compressed / 32-bit instruction counts (macro only)
module kamikaze_compress_encoder #(
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned COMPRESS = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [31:0]      in_instr_i,
  input  logic             flush_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [31:0]      out_word_o,
`ifdef KAMIKAZE_CENC_STATS_EN
  output logic [CNT_W-1:0] stat_c_o,
  output logic [CNT_W-1:0] stat_w_o,
`endif
  output logic             err_o
);

  logic [31:0] w;
  logic [6:0]  op;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [11:0] imm_i, imm_s;
  logic [20:1] imm_j;
  logic [12:1] imm_b;
  logic        rd_p, rs1_p, rs2_p, i6_ok;
  logic        c_ok;
  logic [15:0] c16;

  assign w     = in_instr_i;
  assign op    = w[6:0];
  assign rd    = w[11:7];
  assign f3    = w[14:12];
  assign rs1   = w[19:15];
  assign rs2   = w[24:20];
  assign f7    = w[31:25];
  assign imm_i = w[31:20];
  assign imm_s = {w[31:25], w[11:7]};
  assign imm_j = {w[31], w[19:12], w[20], w[30:21]};
  assign imm_b = {w[31], w[7], w[30:25], w[11:8]};
  // Compressed register fields only reach x8..x15.
  assign rd_p  = (rd[4:3] == 2'b01);
  assign rs1_p = (rs1[4:3] == 2'b01);
  assign rs2_p = (rs2[4:3] == 2'b01);
  assign i6_ok = (imm_i[11:5] == {7{imm_i[5]}});

  // Compression matcher; the if/else order is the rule priority.
  always_comb begin
    c_ok = 1'b0;
    c16  = 16'h0000;
    unique case (op)
      7'h13: begin
        if (f3 == 3'b000) begin
          if (w == 32'h0000_0013) begin
            c_ok = 1'b1;
            c16  = 16'h0001;
          end else if (rs1 == 5'd0 && rd != 5'd0 && i6_ok) begin
            c_ok = 1'b1;
            c16  = {3'b010, imm_i[5], rd, imm_i[4:0], 2'b01};
          end else if (rs1 == rd && rd != 5'd0 && imm_i != 12'd0 && i6_ok) begin
            c_ok = 1'b1;
            c16  = {3'b000, imm_i[5], rd, imm_i[4:0], 2'b01};
          end
        end else if (f3 == 3'b111) begin
          if (rs1 == rd && rd_p && i6_ok) begin
            c_ok = 1'b1;
            c16  = {3'b100, imm_i[5], 2'b10, rd[2:0], imm_i[4:0], 2'b01};
          end
        end else if (f3 == 3'b001) begin
          if (f7 == 7'h00 && rs1 == rd && rd != 5'd0 && rs2 != 5'd0) begin
            c_ok = 1'b1;
            c16  = {4'b0000, rd, rs2, 2'b10};
          end
        end else if (f3 == 3'b101) begin
          if ((f7 == 7'h00 || f7 == 7'h20) && rs1 == rd && rd_p && rs2 != 5'd0) begin
            c_ok = 1'b1;
            c16  = {5'b10000, f7[5], rd[2:0], rs2, 2'b01};
          end
        end
      end
      7'h33: begin
        if (f7 == 7'h00 && f3 == 3'b000 && rd != 5'd0 && rs2 != 5'd0 && rs1 == 5'd0) begin
          c_ok = 1'b1;
          c16  = {4'b1000, rd, rs2, 2'b10};
        end else if (f7 == 7'h00 && f3 == 3'b000 && rd != 5'd0 && rs2 != 5'd0 && rs1 == rd) begin
          c_ok = 1'b1;
          c16  = {4'b1001, rd, rs2, 2'b10};
        end else if (rs1 == rd && rd_p && rs2_p) begin
          if (f7 == 7'h20 && f3 == 3'b000) begin
            c_ok = 1'b1;
            c16  = {6'b100011, rd[2:0], 2'b00, rs2[2:0], 2'b01};
          end else if (f7 == 7'h00 && (f3 == 3'b100 || f3 == 3'b110 || f3 == 3'b111)) begin
            c_ok = 1'b1;
            // xor/or/and map to sub-op 01/10/11 via funct3 low bits (100->01, 110->10, 111->11).
            c16  = {6'b100011, rd[2:0], (f3[1] ? {1'b1, f3[0]} : 2'b01), rs2[2:0], 2'b01};
          end
        end
      end
      7'h67: begin
        if (f3 == 3'b000 && imm_i == 12'd0 && rd[4:1] == 4'd0 && rs1 != 5'd0) begin
          c_ok = 1'b1;
          c16  = {3'b100, rd[0], rs1, 5'b00000, 2'b10};
        end
      end
      7'h6f: begin
        if (rd[4:1] == 4'd0 && imm_j[20:11] == {10{imm_j[11]}}) begin
          c_ok = 1'b1;
          c16  = {~rd[0], 2'b01, imm_j[11], imm_j[4], imm_j[9:8], imm_j[10], imm_j[6], imm_j[7],
                  imm_j[3:1], imm_j[5], 2'b01};
        end
      end
      7'h63: begin
        if (f3[2:1] == 2'b00 && rs2 == 5'd0 && rs1_p && imm_b[12:8] == {5{imm_b[8]}}) begin
          c_ok = 1'b1;
          c16  = {2'b11, f3[0], imm_b[8], imm_b[4:3], rs1[2:0], imm_b[7:6], imm_b[2:1],
                  imm_b[5], 2'b01};
        end
      end
      7'h03: begin
        if (f3 == 3'b010 && imm_i[1:0] == 2'b00) begin
          if (rs1 == 5'd2 && rd != 5'd0 && imm_i[11:8] == 4'd0) begin
            c_ok = 1'b1;
            c16  = {3'b010, imm_i[5], rd, imm_i[4:2], imm_i[7:6], 2'b10};
          end else if (rs1_p && rd_p && imm_i[11:7] == 5'd0) begin
            c_ok = 1'b1;
            c16  = {3'b010, imm_i[5:3], rs1[2:0], imm_i[2], imm_i[6], rd[2:0], 2'b00};
          end
        end
      end
      7'h23: begin
        if (f3 == 3'b010 && imm_s[1:0] == 2'b00) begin
          if (rs1 == 5'd2 && imm_s[11:8] == 4'd0) begin
            c_ok = 1'b1;
            c16  = {3'b110, imm_s[5:2], imm_s[7:6], rs2, 2'b10};
          end else if (rs1_p && rs2_p && imm_s[11:7] == 5'd0) begin
            c_ok = 1'b1;
            c16  = {3'b110, imm_s[5:3], rs1[2:0], imm_s[2], imm_s[6], rs2[2:0], 2'b00};
          end
        end
      end
      default: ;
    endcase
  end

  logic        out_valid_q, out_valid_d;
  logic [31:0] out_word_q, out_word_d;
  logic        hold_vld_q, hold_vld_d;
  logic [15:0] hold_q, hold_d;
  logic        err_q, err_d;
  logic        accept, bad_in, use_c;

  assign in_ready_o = ~out_valid_q | out_ready_i;
  assign accept     = in_valid_i & in_ready_o;
  assign bad_in     = (w[1:0] != 2'b11);
  assign use_c      = (COMPRESS != 0) && c_ok;

  always_comb begin
    out_valid_d = out_valid_q & ~out_ready_i;
    out_word_d  = out_word_q;
    hold_vld_d  = hold_vld_q;
    hold_d      = hold_q;
    err_d       = 1'b0;
    if (accept) begin
      if (bad_in) begin
        err_d = 1'b1;
      end else if (use_c) begin
        if (!hold_vld_q) begin
          hold_d     = c16;
          hold_vld_d = 1'b1;
        end else begin
          out_valid_d = 1'b1;
          out_word_d  = {c16, hold_q};
          hold_vld_d  = 1'b0;
        end
      end else if (!hold_vld_q) begin
        out_valid_d = 1'b1;
        out_word_d  = w;
      end else begin
        // Straddling word: low half goes out now, high half becomes the new pending half.
        out_valid_d = 1'b1;
        out_word_d  = {w[15:0], hold_q};
        hold_d      = w[31:16];
      end
    end else if (flush_i && !in_valid_i && hold_vld_q && in_ready_o) begin
      out_valid_d = 1'b1;
      out_word_d  = {16'h0001, hold_q};
      hold_vld_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_q <= 1'b0;
      out_word_q  <= 32'h0;
      hold_vld_q  <= 1'b0;
      hold_q      <= 16'h0;
      err_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_word_q  <= out_word_d;
      hold_vld_q  <= hold_vld_d;
      hold_q      <= hold_d;
      err_q       <= err_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_word_o  = out_word_q;
  assign err_o       = err_q;

`ifdef KAMIKAZE_CENC_STATS_EN
  logic [CNT_W-1:0] stat_c_q, stat_c_d, stat_w_q, stat_w_d;

  always_comb begin
    stat_c_d = stat_c_q;
    stat_w_d = stat_w_q;
    if (accept && !bad_in) begin
      if (use_c) begin
        if (stat_c_q != {CNT_W{1'b1}}) stat_c_d = stat_c_q + 1'b1;
      end else begin
        if (stat_w_q != {CNT_W{1'b1}}) stat_w_d = stat_w_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stat_c_q <= '0;
      stat_w_q <= '0;
    end else begin
      stat_c_q <= stat_c_d;
      stat_w_q <= stat_w_d;
    end
  end

  assign stat_c_o = stat_c_q;
  assign stat_w_o = stat_w_q;
`else
  logic [CNT_W-1:0] unused_cnt_w;
  assign unused_cnt_w = '0;
`endif

endmodule
